issue_ctrl: RTL

- Decode-to-execute issue controller.
- Takes one decoded instruction per cycle (register valids/addresses, unit one-hot, serialising flag) and holds it until it is hazard-free.
- A per-register pending-write scoreboard blocks RAW hazards and bounds outstanding writes; serialising instructions (CSR, mret, sret, fence) are drained and executed alone.
- Sits between the decoder and the execute units; retires scoreboard entries on writeback.

---
 rtl/issue_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - decode-to-execute issue controller with RAW scoreboard
// Holds one decoded instruction until hazard-free; serialising ops drain and run alone.
module issue_ctrl #(
  parameter int NB_UNIT      = 6,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dec_v_i,
  output logic               dec_ready_o,
  input  logic               dec_rd_v_i,
  input  logic [4:0]         dec_rd_adr_i,
  input  logic               dec_rs1_v_i,
  input  logic [4:0]         dec_rs1_adr_i,
  input  logic               dec_rs2_v_i,
  input  logic [4:0]         dec_rs2_adr_i,
  input  logic [NB_UNIT-1:0] dec_unit_i,
  input  logic               dec_serial_i,
  input  logic [NB_UNIT-1:0] unit_busy_i,
  output logic               issue_v_o,
  input  logic               issue_ready_i,
  input  logic               wbk_v_i,
  input  logic               wbk_rd_v_i,
  input  logic [4:0]         wbk_rd_adr_i,
  input  logic               flush_i,
  output logic [3:0]         inflight_o,
  output logic               err_o
);

  typedef enum logic [1:0] {RUN, DRAIN, SERIAL} state_e;

  state_e           state_q, state_d;
  logic [31:0][1:0] cnt_q, cnt_d;
  logic [3:0]       inflight_q, inflight_d;
  logic             err_q, err_d;
  logic             raw, waw_full, busy, cap, state_ok, can_issue, fire;
  logic             wbk_live, inf_dec, cnt_miss;

  always_comb begin
    raw      = (dec_rs1_v_i && dec_rs1_adr_i != 5'd0 && cnt_q[dec_rs1_adr_i] != 2'd0) ||
               (dec_rs2_v_i && dec_rs2_adr_i != 5'd0 && cnt_q[dec_rs2_adr_i] != 2'd0);
    waw_full = dec_rd_v_i && dec_rd_adr_i != 5'd0 && cnt_q[dec_rd_adr_i] == 2'd3;
    busy     = |(dec_unit_i & unit_busy_i);
    cap      = inflight_q == 4'(MAX_INFLIGHT);

    state_ok = 1'b0;
    state_d  = state_q;
    case (state_q)
      RUN: begin
        state_ok = !dec_serial_i;
        if (dec_v_i && dec_serial_i) state_d = DRAIN;
      end
      DRAIN:   state_ok = (inflight_q == 4'd0);
      SERIAL:  if (inflight_q == 4'd0) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Reset gates the combinational issue so it drops the moment reset asserts.
    can_issue = reset_n && dec_v_i && !raw && !waw_full && !busy && !cap &&
                state_ok && !flush_i;
    fire      = can_issue && issue_ready_i;
    if (state_q == DRAIN && fire) state_d = SERIAL;
    if (flush_i) state_d = RUN;

    wbk_live = wbk_v_i && !flush_i;
    inf_dec  = wbk_live && inflight_q != 4'd0;
    cnt_miss = wbk_live && wbk_rd_v_i && wbk_rd_adr_i != 5'd0 &&
               cnt_q[wbk_rd_adr_i] == 2'd0;
    err_d    = err_q || (wbk_live && (inflight_q == 4'd0 || cnt_miss));

    inflight_d = flush_i ? 4'd0 : inflight_q + 4'(fire) - 4'(inf_dec);

    // Entry 0 stays zero so x0 never reads as pending.
    cnt_d = '0;
    if (!flush_i) begin
      for (int r = 1; r < 32; r++) begin
        cnt_d[r] = cnt_q[r]
                 + 2'(fire && dec_rd_v_i && dec_rd_adr_i == 5'(r))
                 - 2'(wbk_live && wbk_rd_v_i && wbk_rd_adr_i == 5'(r) && cnt_q[r] != 2'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      inflight_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign issue_v_o   = can_issue;
  assign dec_ready_o = fire;
  assign inflight_o  = inflight_q;
  assign err_o       = err_q;

endmodule
